// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART byte receiver: FSM encodings and the default bit period.
package uart_rx_byte_pkg;

  // 10 MHz system clock / 115200 baud
  localparam int unsigned RX_CLKS_PER_BIT_DEFAULT = 87;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte_if.sv
// Parallel-side bundle of the UART receiver: received byte, strobes and debug state.
interface uart_rx_byte_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
  logic [2:0] rx_state;

  modport master (
    output rx_data, rx_valid, rx_frame_err, rx_busy, rx_state
  );

  modport slave (
    input rx_data, rx_valid, rx_frame_err, rx_busy, rx_state
  );

endinterface

// File: rtl/uart_rx_byte_sync_2ff.sv
// 1-bit two-flop synchronizer with a selectable reset level, reusable for any async input pin.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: samples mid-bit, delivers each good byte with a one-cycle strobe.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = RX_CLKS_PER_BIT_DEFAULT
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           RXD,
  uart_rx_byte_if.master rx
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rxd_s;
  logic             rxd_hist_q;

  // Idle-high reset level keeps a reset from looking like a start edge.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RESET),
    .d_i   (RXD),
    .q_o   (rxd_s)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      rxd_hist_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      rxd_hist_q <= rxd_s;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Only a fresh high-to-low transition arms a frame; a held-low line never does.
        if (rxd_hist_q && !rxd_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rxd_s;
          if (bit_idx_q == 3'd7) state_d   = RX_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = RX_IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    rx.rx_data      = data_q;
    rx.rx_valid     = valid_q;
    rx.rx_frame_err = ferr_q;
    rx.rx_busy      = (state_q != RX_IDLE);
    rx.rx_state     = state_q;
  end

endmodule
